// File: rtl/btn_debounce_sync_pkg.sv
// ============================================================
// Package : btn_debounce_sync_pkg
// Brief   : state encoding and defaults for the button debouncer
// Rev     : 1.0  initial release
// ============================================================
`default_nettype none

package btn_debounce_sync_pkg;

    localparam int unsigned c_n_btn_def      = 5;
    localparam int unsigned c_stable_cnt_def = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_CHK_HI  = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_CHK_LO  = 2'd3
    } btn_state_e;

    // Accepted level is high while idling high or qualifying a release.
    function automatic logic st_is_high(input btn_state_e s);
        return (s == ST_IDLE_HI) || (s == ST_CHK_LO);
    endfunction

    function automatic logic st_is_chk(input btn_state_e s);
        return (s == ST_CHK_HI) || (s == ST_CHK_LO);
    endfunction

endpackage : btn_debounce_sync_pkg

`default_nettype wire

// File: rtl/btn_debounce_sync_chan.sv
// ============================================================
// Module : btn_debounce_sync_chan
// Brief  : one channel: 2-flop synchroniser, debounce FSM, strobes
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module btn_debounce_sync_chan
    import btn_debounce_sync_pkg::*;
#(
    parameter int unsigned STABLE_CNT = c_stable_cnt_def
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic busy
);

    localparam int unsigned     CNT_W     = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CNT - 1);

    logic             r_s0;
    logic             r_s1;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_state   <= ST_IDLE_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_s0      <= btn_in;
            r_s1      <= r_s0;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            // Outputs follow the state being entered, so they line up with it.
            r_level   <= st_is_high(w_state_nxt);
            r_busy    <= st_is_chk(w_state_nxt);
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE_LO: begin
                if (r_s1) begin
                    w_state_nxt = ST_CHK_HI;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CHK_HI: begin
                if (!r_s1) begin
                    w_state_nxt = ST_IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_IDLE_HI: begin
                if (!r_s1) begin
                    w_state_nxt = ST_CHK_LO;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CHK_LO: begin
                if (r_s1) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt   = ST_IDLE_LO;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign busy        = r_busy;

endmodule : btn_debounce_sync_chan

`default_nettype wire

// File: rtl/btn_debounce_sync.sv
// ============================================================
// Module : btn_debounce_sync
// Brief  : N independent synchronised, debounced button channels
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module btn_debounce_sync
    import btn_debounce_sync_pkg::*;
#(
    parameter int unsigned N_BTN      = c_n_btn_def,
    parameter int unsigned STABLE_CNT = c_stable_cnt_def
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] busy
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_sync_chan #(
            .STABLE_CNT (STABLE_CNT)
        ) u_chan (
            .clk         (clk),
            .clr         (clr),
            .btn_in      (btn_in[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .busy        (busy[g])
        );
    end

endmodule : btn_debounce_sync

`default_nettype wire
